// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared register file / rename constants
package reg_file_pkg;

    localparam int REG_NUM    = 32;
    localparam int ROB_ID_W   = 5;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [ROB_ID_W-1:0] TAG_NONE = '0;

endpackage

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - one source-operand read port: x0 forcing and commit bypass
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int ROB_ID_W_P = ROB_ID_W
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [ROB_ID_W_P-1:0] tag_rs,
    input  logic [DATA_W-1:0]     value_rs,
    input  logic                  commit_flag,
    input  logic [REG_ADDR_W-1:0] rd_from_rob,
    input  logic [ROB_ID_W_P-1:0] Q_from_rob,
    input  logic [DATA_W-1:0]     V_from_rob,
    output logic [ROB_ID_W_P-1:0] q,
    output logic [DATA_W-1:0]     v
);

    logic is_x0;
    logic bypass;

    always_comb begin
        is_x0  = (rs == '0);
        // The retiring producer is exactly the one this source waits on.
        bypass = commit_flag && (rd_from_rob == rs) && (rd_from_rob != '0)
                 && (tag_rs == Q_from_rob);
        q = tag_rs;
        v = value_rs;
        if (is_x0) begin
            q = '0;
            v = '0;
        end else if (bypass) begin
            q = '0;
            v = V_from_rob;
        end
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file with rename tags and commit bypass
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REG_NUM  = reg_file_pkg::REG_NUM,
    parameter int ROB_ID_W = reg_file_pkg::ROB_ID_W
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rollback_flag,
    input  logic                  commit_flag,
    input  logic [REG_ADDR_W-1:0] rd_from_rob,
    input  logic [ROB_ID_W-1:0]   Q_from_rob,
    input  logic [DATA_W-1:0]     V_from_rob,
    input  logic [REG_ADDR_W-1:0] rs1_from_dispatcher,
    input  logic [REG_ADDR_W-1:0] rs2_from_dispatcher,
    input  logic                  rename_en_from_dispatcher,
    input  logic [REG_ADDR_W-1:0] rd_from_dispatcher,
    input  logic [ROB_ID_W-1:0]   rob_id_from_dispatcher,
    output logic [ROB_ID_W-1:0]   Q1_to_dispatcher,
    output logic [DATA_W-1:0]     V1_to_dispatcher,
    output logic [ROB_ID_W-1:0]   Q2_to_dispatcher,
    output logic [DATA_W-1:0]     V2_to_dispatcher
);

    logic [DATA_W-1:0]   value_q [REG_NUM];
    logic [ROB_ID_W-1:0] tag_q   [REG_NUM];

    logic commit_wr;
    logic commit_clr;
    logic rename_wr;

    always_comb begin
        commit_wr  = commit_flag && (rd_from_rob != '0);
        commit_clr = commit_wr && (tag_q[rd_from_rob] == Q_from_rob);
        rename_wr  = rename_en_from_dispatcher && (rd_from_dispatcher != '0);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (commit_wr) begin
                value_q[rd_from_rob] <= V_from_rob;
            end
            if (rollback_flag) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    tag_q[i] <= '0;
                end
            end else begin
                if (commit_clr) begin
                    tag_q[rd_from_rob] <= '0;
                end
                // Ordered after the commit clear so a same-register rename keeps the new tag.
                if (rename_wr) begin
                    tag_q[rd_from_dispatcher] <= rob_id_from_dispatcher;
                end
            end
        end
    end

    reg_read_port #(.ROB_ID_W_P(ROB_ID_W)) u_port1 (
        .rs          (rs1_from_dispatcher),
        .tag_rs      (tag_q[rs1_from_dispatcher]),
        .value_rs    (value_q[rs1_from_dispatcher]),
        .commit_flag (commit_flag),
        .rd_from_rob (rd_from_rob),
        .Q_from_rob  (Q_from_rob),
        .V_from_rob  (V_from_rob),
        .q           (Q1_to_dispatcher),
        .v           (V1_to_dispatcher)
    );

    reg_read_port #(.ROB_ID_W_P(ROB_ID_W)) u_port2 (
        .rs          (rs2_from_dispatcher),
        .tag_rs      (tag_q[rs2_from_dispatcher]),
        .value_rs    (value_q[rs2_from_dispatcher]),
        .commit_flag (commit_flag),
        .rd_from_rob (rd_from_rob),
        .Q_from_rob  (Q_from_rob),
        .V_from_rob  (V_from_rob),
        .q           (Q2_to_dispatcher),
        .v           (V2_to_dispatcher)
    );

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, number of architectural registers.
REQ-002 SHALL have parameter ROB_ID_W, default 5, tag width; tag 0 means "no pending producer".
REQ-003 clk_in  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_in  input  1  asynchronous, active-high reset.
REQ-005 rdy_in  input  1  global enable; low freezes all state.
REQ-006 rollback_flag  input  1  mispredict flush from reorder buffer.
REQ-007 commit_flag  input  1  reorder buffer retires one instruction this cycle.
REQ-008 rd_from_rob  input  5  commit destination register.
REQ-009 Q_from_rob  input  ROB_ID_W  commit tag (reorder-buffer index + 1).
REQ-010 V_from_rob  input  32  commit value.
REQ-011 rs1_from_dispatcher, rs2_from_dispatcher  input  5 each  source register queries.
REQ-012 rename_en_from_dispatcher  input  1  bind rd to a new tag.
REQ-013 rd_from_dispatcher  input  5  destination being renamed.
REQ-014 rob_id_from_dispatcher  input  ROB_ID_W  tag assigned to rd.
REQ-015 Q1_to_dispatcher, Q2_to_dispatcher  output  ROB_ID_W  pending tag of rs1/rs2, 0 if value final.
REQ-016 V1_to_dispatcher, V2_to_dispatcher  output  32  register value of rs1/rs2, meaningful when Q is 0.

Function
REQ-017 State SHALL be value[REG_NUM] (32 bit) and tag[REG_NUM] (ROB_ID_W bit).
REQ-018 Read ports SHALL be combinational, zero-cycle, from pre-edge state.
REQ-019 Query of x0 SHALL return Q=0, V=0 unconditionally.
REQ-020 Commit bypass: if commit_flag, rd_from_rob==rsN, rd_from_rob!=0 and tag[rsN]==Q_from_rob, port N SHALL return Q=0, V=V_from_rob.
REQ-021 Otherwise port N SHALL return tag[rsN], value[rsN].
REQ-022 Commit: if commit_flag and rd_from_rob!=0, value[rd] SHALL be written with V_from_rob next edge, regardless of tag.
REQ-023 Commit: tag[rd] SHALL be cleared to 0 only when tag[rd]==Q_from_rob; a newer tag is kept.
REQ-024 Rename: if rename_en and rd_from_dispatcher!=0 and no rollback, tag[rd] SHALL become rob_id_from_dispatcher.
REQ-025 Rename and commit to the same rd in one cycle: rename SHALL win the tag; value still written.
REQ-026 Rename of rd equal to rs1/rs2 in the same cycle SHALL NOT affect that cycle's read outputs.
REQ-027 Rollback: all tags SHALL clear to 0 next edge; values retained; same-cycle commit value write still performed; same-cycle rename ignored.
REQ-028 x0 value and tag SHALL remain 0 forever.
REQ-029 rdy_in low: no state change; read outputs still track inputs combinationally.

Reset
REQ-030 On rst_in high, all value and tag entries SHALL be 0 immediately (asynchronous), held while asserted.
REQ-031 Consequently all outputs SHALL read Q=0, V=0 during reset, bypass excepted (REQ-020 with commit inputs active).
REQ-032 Reset SHALL override rollback, commit, rename and rdy_in.

Structure
REQ-033 Shared package SHALL hold REG_NUM, ROB_ID_W, TAG_NONE (=0) and the 32-bit data width constant, also used by the reorder buffer and dispatcher.
REQ-034 One sub-module, reg_read_port (x0 check + commit bypass mux), SHALL be instantiated twice.
REQ-035 Storage and update logic SHALL live in reg_file itself.

Verification
REQ-036 Reset, query rs1=5 rs2=0 -> Q1=0 V1=0, Q2=0 V2=0.
REQ-037 Rename x5->tag 3; next cycle query x5 -> Q1=3; commit rd=5 Q=3 V=0x1234 same cycle -> Q1=0 V1=0x1234; after edge tag[5]=0 value 0x1234.
REQ-038 Rename x5->3, then x5->7; commit rd=5 Q=3 V=0xAA -> value 0xAA, tag stays 7, query returns Q=7.
REQ-039 Rename x6->4 with commit rd=6 Q=4 V=0x55 in same cycle -> tag[6]=4 after edge, value 0x55.
REQ-040 Tags on x1,x2,x3 = 2,5,9; rollback with commit rd=1 Q=2 V=0x10 and rename x4->11 -> all tags 0, value[1]=0x10, tag[4]=0.
REQ-041 Commit rd=0 V=0xFFFF and rename x0->6 -> x0 reads Q=0 V=0; rdy_in=0 with commit rd=7 -> value[7] unchanged.
